// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
//
// Bit-serial ripple adder. A single full-adder slice works through two
// WIDTH-bit operands one bit per clock, LSB first, keeping the running carry
// in a register between cycles. A start/done handshake wraps the datapath so
// that the adder looks like an ordinary multi-cycle sequential unit.
//
// Timing (E0 = edge that accepts start):
//   E0              operands captured, busy rises
//   E1 .. E_WIDTH   one result bit per edge
//   E_WIDTH         sum/cout updated, done pulses, busy falls
//   E_WIDTH+1       back to IDLE; the earliest new start is taken at E_WIDTH+2
//
// Parameters:
//   WIDTH   operand/result width in bits (2..32), default 8
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   start   in   request, only looked at while idle
//   a, b    in   WIDTH-bit operands, captured on the accepted start edge
//   cin     in   carry-in, captured on the accepted start edge
//   busy    out  high while an addition is in progress
//   done    out  one-cycle completion pulse
//   sum     out  WIDTH-bit result, held until the next completion
//   cout    out  final carry-out, held together with sum
//   ovf     out  (only with SERIAL_ADDER_OVF_EN) signed two's-complement
//                overflow of the last result, held together with sum
//
// Build option:
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its register.
// -----------------------------------------------------------------------------

`timescale 1ns/1ps

module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Bit counter only has to reach WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry: majority of the three inputs.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;

  // a_sh_r doubles as the result accumulator: each RUN edge consumes the
  // operand bit at [0] and inserts the new sum bit at the MSB, so after
  // WIDTH-1 shifts the upper WIDTH-1 bits hold the result computed so far.
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             bit_s;
  logic             carry_nxt_s;
  logic             last_s;

  // Single full-adder slice on the current LSBs plus the held carry.
  always_comb begin
    bit_s       = fa_sum(a_sh_r[0], b_sh_r[0], carry_r);
    carry_nxt_s = fa_carry(a_sh_r[0], b_sh_r[0], carry_r);
    last_s      = (cnt_r == LAST_CNT);
  end

  // State register; any unknown encoding is sent back to IDLE by next-state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh_r  <= {bit_s, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= carry_nxt_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            // Newly computed bit lands as the result MSB.
            sum_r  <= {bit_s, a_sh_r[WIDTH-1:1]};
            cout_r <= carry_nxt_s;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            done_r <= 1'b0;
            busy_r <= 1'b1;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // On the completion edge carry_r is the carry into the MSB slice and
  // carry_nxt_s the carry out of it; their XOR is signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if ((state_r == S_RUN) && last_s) begin
      ovf_r <= carry_r ^ carry_nxt_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_fsm.sv
`timescale 1ns/1ps

module tb_serial_adder_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start3 = 1'b0;
  logic [2:0] a3 = 3'b000;
  logic [2:0] b3 = 3'b000;
  logic       cin3 = 1'b0;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf3;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_adder_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder_fsm #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf3)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic.
  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return 9'(s);
  endfunction

  // Reference model: signed result out of range means overflow.
  function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  // Launch one addition; returns at the falling edge right after E0.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
  endtask

  // Advance until done is seen (or the bound expires), counting busy cycles.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0; busy_cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, cout, sum} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, cout, sum} !== 11'h000) begin
        miscompares++;
        $display("FAIL idle_hold cycle %0d: got busy=%b done=%b sum=%h cout=%b, want all 0", i, busy, done, sum, cout);
      end
    end
    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vs_start: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_carry_ripple();
    int cyc, bcyc;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(cyc, bcyc);
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL ripple_latency: got %0d cycles, want 8", cyc);
    end
    vectors++;
    if (bcyc !== 8) begin
      miscompares++;
      $display("FAIL ripple_busy: got %0d busy cycles, want 8", bcyc);
    end
    vectors++;
    if ({cout, sum} !== 9'h100) begin
      miscompares++;
      $display("FAIL ripple_result: got cout=%b sum=%h, want cout=1 sum=00", cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_ovf: got %b, want 0", ovf);
    end
`endif
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL ripple_done_width: done still %b one cycle later, want 0", done);
    end
  endtask

  task automatic test_carry_in();
    int cyc, bcyc;
    logic held_ok;
    start_op(8'hA5, 8'h5A, 1'b1);
    wait_done(cyc, bcyc);
    vectors++;
    if ({cout, sum} !== 9'h100 || cyc !== 8) begin
      miscompares++;
      $display("FAIL cin_result: got cout=%b sum=%h after %0d cycles, want cout=1 sum=00 after 8", cout, sum, cyc);
    end
    start_op(8'h12, 8'h34, 1'b0);
    held_ok = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (sum !== 8'h00 || cout !== 1'b1) held_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (held_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL output_hold: got held_ok=%b, want 1 (sum/cout changed before completion)", held_ok);
    end
    vectors++;
    if ({cout, sum} !== 9'h046 || cyc !== 8) begin
      miscompares++;
      $display("FAIL second_result: got cout=%b sum=%h after %0d cycles, want cout=0 sum=46 after 8", cout, sum, cyc);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, bcyc, pulses;
    start_op(8'h0F, 8'h01, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcyc);
    vectors++;
    if (cyc !== 5) begin
      miscompares++;
      $display("FAIL busy_start_latency: got %0d cycles after E3, want 5", cyc);
    end
    vectors++;
    if ({cout, sum} !== 9'h010) begin
      miscompares++;
      $display("FAIL busy_start_result: got cout=%b sum=%h, want cout=0 sum=10", cout, sum);
    end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got %0d extra busy/done cycles, want 0", pulses);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcyc, pulses;
    start_op(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, cout, sum} !== 11'h000) begin
      miscompares++;
      $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b, want all 0", busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL midrun_no_done: got %0d busy/done cycles after abort, want 0", pulses);
    end
    start_op(8'h03, 8'h04, 1'b0);
    wait_done(cyc, bcyc);
    vectors++;
    if ({cout, sum} !== 9'h007 || cyc !== 8) begin
      miscompares++;
      $display("FAIL after_abort: got cout=%b sum=%h after %0d cycles, want cout=0 sum=07 after 8", cout, sum, cyc);
    end
  endtask

  task automatic test_random();
    int cyc, bcyc;
    logic [7:0] x, y;
    logic c;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      if (i == 0) begin x = 8'h7F; y = 8'h01; c = 1'b0; end
      if (i == 1) begin x = 8'h80; y = 8'h80; c = 1'b1; end
      start_op(x, y, c);
      wait_done(cyc, bcyc);
      vectors++;
      if ({cout, sum} !== ref_add8(x, y, c) || cyc !== 8) begin
        miscompares++;
        $display("FAIL random %0d: %h+%h+%b got %h after %0d cycles, want %h after 8",
                 i, x, y, c, {cout, sum}, cyc, ref_add8(x, y, c));
      end
`ifdef SERIAL_ADDER_OVF_EN
      vectors++;
      if (ovf !== ref_ovf8(x, y, c)) begin
        miscompares++;
        $display("FAIL random_ovf %0d: %h+%h+%b got %b, want %b", i, x, y, c, ovf, ref_ovf8(x, y, c));
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs[5];
    logic [7:0] ys[5];
    logic       cs[5];
    int cyc;
    for (int i = 0; i < 5; i++) begin
      xs[i] = 8'($urandom); ys[i] = 8'($urandom); cs[i] = 1'($urandom);
    end
    @(negedge clk);
    a = xs[0]; b = ys[0]; cin = cs[0]; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (done !== 1'b1 && cyc < 40);
      vectors++;
      if ({cout, sum} !== ref_add8(xs[i], ys[i], cs[i])) begin
        miscompares++;
        $display("FAIL b2b_result %0d: got %h, want %h", i, {cout, sum}, ref_add8(xs[i], ys[i], cs[i]));
      end
      vectors++;
      if (cyc !== ((i == 0) ? 9 : 10)) begin
        miscompares++;
        $display("FAIL b2b_period %0d: got %0d cycles, want %0d", i, cyc, (i == 0) ? 9 : 10);
      end
      a = xs[i+1]; b = ys[i+1]; cin = cs[i+1];
      if (i == 3) start = 1'b0;
    end
  endtask

  task automatic test_width3_sweep();
    logic [2:0] x, y;
    logic c;
    int cyc, s;
    logic [3:0] exp_v;
    for (int v = 0; v < 128; v++) begin
      x = 3'(v >> 4); y = 3'(v >> 1); c = 1'(v);
      @(negedge clk);
      a3 = x; b3 = y; cin3 = c; start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      cyc = 0;
      while (done3 !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      exp_v = 4'(int'(x) + int'(y) + int'(c));
      vectors++;
      if ({cout3, sum3} !== exp_v || cyc !== 3 || busy3 !== 1'b0) begin
        miscompares++;
        $display("FAIL w3 %0d: %b+%b+%b got %b after %0d cycles busy=%b, want %b after 3 busy=0",
                 v, x, y, c, {cout3, sum3}, cyc, busy3, exp_v);
      end
`ifdef SERIAL_ADDER_OVF_EN
      s = int'($signed(x)) + int'($signed(y)) + int'(c);
      vectors++;
      if (ovf3 !== ((s > 3) || (s < -4))) begin
        miscompares++;
        $display("FAIL w3_ovf %0d: %b+%b+%b got %b, want %b", v, x, y, c, ovf3, (s > 3) || (s < -4));
      end
`else
      s = 0;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    test_width3_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
